// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg
// Purpose  : ID/EX pipeline register. Latches the decoded control bundle,
//            operands, immediate, register indices and pc+4 into EX, detects
//            load-use hazards (stall IF/ID, inject a NOP bubble), honours
//            branch/jump flush and downstream hold, and counts load-use
//            bubbles in a saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [19:0]       id_ctrl,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              ex_valid,
    output logic [19:0]       ex_ctrl,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_wreg,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Bit positions inside the 20-bit control bundle
    // {pad[19:17], LS_bit[16:15], RegDst, Branch[13:12], MemtoReg, ALUSrc,
    //  ALUOp[9:6], MemWrite, RegWrite, Jump, Ext_op, PctoReg, JR}
    localparam int c_B_PCTOREG   = 1;
    localparam int c_B_JUMP      = 3;
    localparam int c_B_REGWRITE  = 4;
    localparam int c_B_MEMWRITE  = 5;
    localparam int c_B_ALUSRC    = 10;
    localparam int c_B_MEMTOREG  = 11;
    localparam int c_B_BRANCH_LO = 12;
    localparam int c_B_BRANCH_HI = 13;
    localparam int c_B_REGDST    = 14;

    localparam logic [REG_AW-1:0] c_LINK_REG = REG_AW'(31);
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;

    logic              r_ex_valid;
    logic [19:0]       r_ex_ctrl;
    logic [DATA_W-1:0] r_ex_pc4;
    logic [DATA_W-1:0] r_ex_rs_data;
    logic [DATA_W-1:0] r_ex_rt_data;
    logic [DATA_W-1:0] r_ex_imm;
    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    logic [REG_AW-1:0] r_ex_wreg;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_load_ex;
    logic              w_uses_rs;
    logic              w_uses_rt;
    logic              w_hazard;
    logic              w_stall;
    logic [REG_AW-1:0] w_id_wreg;

    // A load in EX only matters when it really writes a non-zero register
    assign w_load_ex = r_ex_valid
                     & r_ex_ctrl[c_B_MEMTOREG]
                     & r_ex_ctrl[c_B_REGWRITE]
                     & (r_ex_wreg != '0);

    // Jumps ignore rs; rt is read by R-type ALU ops, stores and branches
    assign w_uses_rs = ~id_ctrl[c_B_JUMP];
    assign w_uses_rt = ~id_ctrl[c_B_ALUSRC]
                     | id_ctrl[c_B_MEMWRITE]
                     | (id_ctrl[c_B_BRANCH_HI:c_B_BRANCH_LO] != 2'b00);

    assign w_hazard = id_valid & w_load_ex
                    & ((w_uses_rs & (r_ex_wreg == id_rs))
                     | (w_uses_rt & (r_ex_wreg == id_rt)));

    // A flush discards the dependent instruction and a hold freezes EX
    // anyway, so neither case needs the front end frozen for the hazard
    assign w_stall = w_hazard & ~flush & ~ex_hold;

    // Destination register chosen at latch time: link register for JAL
    assign w_id_wreg = id_ctrl[c_B_PCTOREG] ? c_LINK_REG :
                       id_ctrl[c_B_REGDST]  ? id_rd      : id_rt;

    // Pipeline register: flush > hold > hazard bubble > normal latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= '0;
            r_ex_pc4     <= '0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
            r_ex_imm     <= '0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_wreg    <= '0;
        end else if (flush || (!ex_hold && w_hazard)) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= '0;
            r_ex_pc4     <= '0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
            r_ex_imm     <= '0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_wreg    <= '0;
        end else if (!ex_hold) begin
            r_ex_valid   <= id_valid;
            r_ex_ctrl    <= id_valid ? id_ctrl : '0;
            r_ex_pc4     <= id_pc4;
            r_ex_rs_data <= id_rs_data;
            r_ex_rt_data <= id_rt_data;
            r_ex_imm     <= id_imm;
            r_ex_rs      <= id_rs;
            r_ex_rt      <= id_rt;
            r_ex_wreg    <= id_valid ? w_id_wreg : '0;
        end
    end

    // Saturating count of bubbles injected by load-use stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_stall && (r_bubble_cnt != c_CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_ctrl    = r_ex_ctrl;
    assign ex_pc4     = r_ex_pc4;
    assign ex_rs_data = r_ex_rs_data;
    assign ex_rt_data = r_ex_rt_data;
    assign ex_imm     = r_ex_imm;
    assign ex_rs      = r_ex_rs;
    assign ex_rt      = r_ex_rt;
    assign ex_wreg    = r_ex_wreg;
    assign stall      = w_stall;
    assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage_reg
// Purpose  : Self-checking bench for id_ex_stage_reg. Directed instruction
//            sequences plus random traffic, compared against a cycle-level
//            behavioural model of the EX slot and bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;   // small counter so saturation is reachable quickly

    // {pad3, LS2, RegDst, Branch2, MemtoReg, ALUSrc, ALUOp4, MemWrite, RegWrite, Jump, Ext_op, PctoReg, JR}
    localparam logic [19:0] LW   = {3'b0, 2'b10, 1'b0, 2'b00, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [19:0] ADD  = {3'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] ADDI = {3'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [19:0] SW   = {3'b0, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [19:0] BEQ  = {3'b0, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [19:0] JMP  = {3'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] JAL  = {3'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [19:0] JR   = {3'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              id_valid = 1'b0;
    logic [19:0]       id_ctrl = '0;
    logic [DATA_W-1:0] id_pc4 = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [REG_AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic              flush = 1'b0, ex_hold = 1'b0;
    logic              ex_valid;
    logic [19:0]       ex_ctrl;
    logic [DATA_W-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_wreg;
    logic              stall;
    logic [CNT_W-1:0]  bubble_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model of the EX slot
    logic              m_valid;
    logic [19:0]       m_ctrl;
    logic [DATA_W-1:0] m_pc4, m_rs_data, m_rt_data, m_imm;
    logic [REG_AW-1:0] m_rs, m_rt, m_wreg;
    int                m_cnt;
    bit                m_defined;   // data fields are only specified for real instructions and bubbles

    id_ex_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_wreg(ex_wreg), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Instruction-level meaning of the control bundle
    function automatic bit is_load(input logic [19:0] c);
        return c[11] && c[4];
    endfunction

    function automatic bit reads_rs(input logic [19:0] c);
        return !c[3];
    endfunction

    function automatic bit reads_rt(input logic [19:0] c);
        return !c[10] || c[5] || (c[13:12] != 2'b00);
    endfunction

    function automatic logic [REG_AW-1:0] dest_of(input logic [19:0] c, input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd);
        if (c[1]) return 5'd31;
        if (c[14]) return rd;
        return rt;
    endfunction

    function automatic bit model_hazard();
        if (!id_valid || !m_valid || !is_load(m_ctrl) || m_wreg == 0) return 1'b0;
        return (reads_rs(id_ctrl) && m_wreg == id_rs) || (reads_rt(id_ctrl) && m_wreg == id_rt);
    endfunction

    task automatic model_clear(input bit clr_cnt);
        m_valid = 1'b0; m_ctrl = '0; m_pc4 = '0; m_rs_data = '0; m_rt_data = '0;
        m_imm = '0; m_rs = '0; m_rt = '0; m_wreg = '0; m_defined = 1'b1;
        if (clr_cnt) m_cnt = 0;
    endtask

    task automatic set_id(input logic v, input logic [19:0] c, input logic [REG_AW-1:0] rs,
                          input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd);
        id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
        id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    endtask

    // One clock: check stall against the model, advance the model, check EX after the edge
    task automatic cycle();
        bit hz, exp_stall;
        #1;
        hz = model_hazard();
        exp_stall = hz && !flush && !ex_hold;
        checks++;
        if (stall !== exp_stall) begin
            failures++;
            $display("FAIL stall t=%0t got=%b exp=%b", $time, stall, exp_stall);
        end
        if (flush) begin
            model_clear(1'b0);
        end else if (ex_hold) begin
            // EX keeps its contents
        end else if (hz) begin
            model_clear(1'b0);
            if (m_cnt < (2**CNT_W - 1)) m_cnt++;
        end else begin
            m_valid = id_valid; m_ctrl = id_valid ? id_ctrl : '0;
            m_pc4 = id_pc4; m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
            m_rs = id_rs; m_rt = id_rt; m_wreg = id_valid ? dest_of(id_ctrl, id_rt, id_rd) : '0;
            m_defined = id_valid;
        end
        @(posedge clk);
        #1;
        checks++;
        if (ex_valid !== m_valid || ex_ctrl !== m_ctrl || bubble_cnt !== CNT_W'(m_cnt)) begin
            failures++;
            $display("FAIL ex_state t=%0t got valid=%b ctrl=%h cnt=%0d exp valid=%b ctrl=%h cnt=%0d",
                     $time, ex_valid, ex_ctrl, bubble_cnt, m_valid, m_ctrl, m_cnt);
        end
        if (m_defined) begin
            checks++;
            if ({ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_wreg} !==
                {m_pc4, m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_wreg}) begin
                failures++;
                $display("FAIL ex_data t=%0t got pc4=%h rs=%h rt=%h imm=%h ri=%0d ti=%0d w=%0d exp pc4=%h rs=%h rt=%h imm=%h ri=%0d ti=%0d w=%0d",
                         $time, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_wreg,
                         m_pc4, m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_wreg);
            end
        end
    endtask

    task automatic test_reset();
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd0);
        #3;
        checks++;
        if ({ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_wreg, stall, bubble_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_state got valid=%b ctrl=%h pc4=%h w=%0d stall=%b cnt=%0d exp all zero",
                     ex_valid, ex_ctrl, ex_pc4, ex_wreg, stall, bubble_cnt);
        end
        model_clear(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_load_use();
        int base;
        base = m_cnt;
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd0);        // lw $2,0($1)
        cycle();
        set_id(1'b1, ADD, 5'd2, 5'd4, 5'd3);       // add $3,$2,$4
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL load_use_stall got=%b exp=1", stall);
        end
        cycle();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 20'h0 || bubble_cnt !== CNT_W'(base + 1)) begin
            failures++;
            $display("FAIL load_use_bubble got valid=%b ctrl=%h cnt=%0d exp valid=0 ctrl=0 cnt=%0d",
                     ex_valid, ex_ctrl, bubble_cnt, base + 1);
        end
        cycle();
        checks++;
        if (ex_valid !== 1'b1 || ex_ctrl !== ADD || ex_wreg !== 5'd3 || stall !== 1'b0) begin
            failures++;
            $display("FAIL load_use_advance got valid=%b ctrl=%h wreg=%0d stall=%b exp valid=1 ctrl=%h wreg=3 stall=0",
                     ex_valid, ex_ctrl, ex_wreg, stall, ADD);
        end
    endtask

    task automatic test_reset_mid();
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd0);
        cycle();
        set_id(1'b1, ADD, 5'd2, 5'd2, 5'd6);       // would stall
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_wreg, stall, bubble_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_mid got valid=%b ctrl=%h w=%0d stall=%b cnt=%0d exp all zero",
                     ex_valid, ex_ctrl, ex_wreg, stall, bubble_cnt);
        end
        model_clear(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();                                    // first cycle after release latches normally
    endtask

    task automatic test_no_hazard();
        int base;
        base = m_cnt;
        set_id(1'b1, LW, 5'd1, 5'd0, 5'd0);        // lw $0
        cycle();
        set_id(1'b1, ADD, 5'd0, 5'd0, 5'd5);       // add $5,$0,$0
        cycle();
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd0);        // lw $2
        cycle();
        set_id(1'b1, JMP, 5'd2, 5'd5, 5'd0);       // j: rs field aliases $2
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL no_hazard_jump got=%b exp=0", stall);
        end
        cycle();
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd0);
        cycle();
        set_id(1'b1, ADDI, 5'd6, 5'd5, 5'd0);      // addi $5,$6,1
        cycle();
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd0);
        cycle();
        set_id(1'b1, ADDI, 5'd6, 5'd2, 5'd0);      // addi $2,$6,1 : rt is a destination
        cycle();
        checks++;
        if (bubble_cnt !== CNT_W'(base)) begin
            failures++;
            $display("FAIL no_hazard_cnt got=%0d exp=%0d", bubble_cnt, base);
        end
    endtask

    task automatic test_flush();
        int base;
        base = m_cnt;
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd0);
        cycle();
        set_id(1'b1, ADD, 5'd2, 5'd4, 5'd3);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall got=%b exp=0", stall);
        end
        cycle();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 20'h0 || bubble_cnt !== CNT_W'(base)) begin
            failures++;
            $display("FAIL flush_bubble got valid=%b ctrl=%h cnt=%0d exp valid=0 ctrl=0 cnt=%0d",
                     ex_valid, ex_ctrl, bubble_cnt, base);
        end
        flush = 1'b0;
        set_id(1'b1, ADD, 5'd1, 5'd4, 5'd3);
        cycle();
        flush = 1'b1;
        ex_hold = 1'b1;
        cycle();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 20'h0 || ex_pc4 !== '0) begin
            failures++;
            $display("FAIL flush_hold got valid=%b ctrl=%h pc4=%h exp all zero", ex_valid, ex_ctrl, ex_pc4);
        end
        flush = 1'b0;
        ex_hold = 1'b0;
    endtask

    task automatic test_hold();
        logic [DATA_W-1:0] pc4_s;
        set_id(1'b1, ADD, 5'd1, 5'd2, 5'd7);
        pc4_s = id_pc4;
        cycle();
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, SW, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'd4);
            cycle();
            checks++;
            if (ex_valid !== 1'b1 || ex_ctrl !== ADD || ex_pc4 !== pc4_s || ex_wreg !== 5'd7) begin
                failures++;
                $display("FAIL hold_const i=%0d got valid=%b ctrl=%h pc4=%h w=%0d exp valid=1 ctrl=%h pc4=%h w=7",
                         i, ex_valid, ex_ctrl, ex_pc4, ex_wreg, ADD, pc4_s);
            end
        end
        ex_hold = 1'b0;
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd0);
        cycle();
        ex_hold = 1'b1;
        set_id(1'b1, ADD, 5'd2, 5'd4, 5'd3);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL hold_hazard_stall got=%b exp=0", stall);
        end
        cycle();
        checks++;
        if (ex_ctrl !== LW || ex_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_hazard_keep got valid=%b ctrl=%h exp valid=1 ctrl=%h", ex_valid, ex_ctrl, LW);
        end
        ex_hold = 1'b0;
        cycle();                                    // hazard now inserts the bubble
        cycle();                                    // add advances
    endtask

    task automatic test_wreg();
        set_id(1'b0, 20'h0, 5'd0, 5'd0, 5'd0);
        cycle();
        set_id(1'b1, JAL, 5'd3, 5'd4, 5'd5);
        id_pc4 = 32'h40;
        cycle();
        checks++;
        if (ex_wreg !== 5'd31 || ex_pc4 !== 32'h40) begin
            failures++;
            $display("FAIL wreg_jal got wreg=%0d pc4=%h exp wreg=31 pc4=00000040", ex_wreg, ex_pc4);
        end
        set_id(1'b1, ADD, 5'd1, 5'd2, 5'd7);
        cycle();
        checks++;
        if (ex_wreg !== 5'd7) begin
            failures++;
            $display("FAIL wreg_rtype got=%0d exp=7", ex_wreg);
        end
        set_id(1'b1, ADDI, 5'd3, 5'd9, 5'd12);
        cycle();
        checks++;
        if (ex_wreg !== 5'd9) begin
            failures++;
            $display("FAIL wreg_addi got=%0d exp=9", ex_wreg);
        end
        set_id(1'b1, JR, 5'd31, 5'd0, 5'd0);
        cycle();
        checks++;
        if (ex_wreg !== 5'd0) begin
            failures++;
            $display("FAIL wreg_jr got=%0d exp=0", ex_wreg);
        end
    endtask

    task automatic test_random();
        logic [19:0] kinds [8];
        int k;
        kinds = '{LW, ADD, ADDI, SW, BEQ, JMP, JAL, JR};
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 8);
            set_id(($urandom_range(0, 7) != 0),
                   (k == 8) ? {3'b0, 17'($urandom)} : kinds[k],
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            flush   = ($urandom_range(0, 9) == 0);
            ex_hold = ($urandom_range(0, 7) == 0);
            cycle();
        end
        flush = 1'b0;
        ex_hold = 1'b0;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 2**CNT_W + 3; i++) begin
            set_id(1'b1, LW, 5'd1, 5'd2, 5'd0);
            cycle();
            set_id(1'b1, BEQ, 5'd3, 5'd2, 5'd0);   // beq reads rt=$2
            cycle();
            cycle();
        end
        checks++;
        if (bubble_cnt !== {CNT_W{1'b1}}) begin
            failures++;
            $display("FAIL saturate got=%0d exp=%0d", bubble_cnt, 2**CNT_W - 1);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_reset_mid();
        test_no_hazard();
        test_flush();
        test_hold();
        test_wreg();
        test_random();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
